// File: rtl/mem_bus_arbiter.sv
// Arbitrates one shared 32-bit memory bus between the instruction-fetch port and the data port.
// One transaction at a time. The slave completes it with bus_ack_i. A hung slave is aborted after TIMEOUT busy cycles.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ack_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [3:0]  d_sel_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_rdata_o,
    output logic        d_ack_o,
    output logic        bus_ce_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        err_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        I_BUSY = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state, state_nx;
    logic       last_grant_data;
    logic [7:0] cnt;
    logic       grant_d, grant_i, finish, timed_out, owner_req;

    always_comb begin
        state_nx  = state;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        finish    = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                // Data wins a tie unless it won the previous grant, so neither side starves.
                if (d_req_i && (!if_req_i || !last_grant_data)) begin
                    grant_d  = 1'b1;
                    state_nx = D_BUSY;
                end else if (if_req_i) begin
                    grant_i  = 1'b1;
                    state_nx = I_BUSY;
                end
            end
            D_BUSY, I_BUSY: begin
                if (bus_ack_i) begin
                    finish   = 1'b1;
                    state_nx = IDLE;
                end else if (cnt == TIMEOUT_CNT) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A requester that withdrew mid-transfer gets no ack and keeps its old data.
    assign owner_req = (state == D_BUSY) ? d_req_i : if_req_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            last_grant_data <= 1'b0;
            cnt             <= 8'd0;
            if_data_o       <= 32'd0;
            if_ack_o        <= 1'b0;
            d_rdata_o       <= 32'd0;
            d_ack_o         <= 1'b0;
            bus_ce_o        <= 1'b0;
            bus_we_o        <= 1'b0;
            bus_addr_o      <= 32'd0;
            bus_sel_o       <= 4'd0;
            bus_wdata_o     <= 32'd0;
            err_o           <= 1'b0;
        end else begin
            state    <= state_nx;
            if_ack_o <= 1'b0;
            d_ack_o  <= 1'b0;
            err_o    <= 1'b0;
            if (grant_d) begin
                bus_ce_o        <= 1'b1;
                bus_we_o        <= d_we_i;
                bus_addr_o      <= d_addr_i;
                bus_sel_o       <= d_sel_i;
                bus_wdata_o     <= d_we_i ? d_wdata_i : 32'd0;
                last_grant_data <= 1'b1;
                cnt             <= 8'd0;
            end else if (grant_i) begin
                bus_ce_o        <= 1'b1;
                bus_we_o        <= 1'b0;
                bus_addr_o      <= if_addr_i;
                bus_sel_o       <= 4'b1111;
                bus_wdata_o     <= 32'd0;
                last_grant_data <= 1'b0;
                cnt             <= 8'd0;
            end else if (finish) begin
                bus_ce_o <= 1'b0;
                if (owner_req) begin
                    err_o <= timed_out;
                    if (state == D_BUSY) begin
                        d_ack_o <= 1'b1;
                        if (timed_out)
                            d_rdata_o <= 32'd0;
                        else if (!bus_we_o)
                            d_rdata_o <= bus_rdata_i;
                    end else begin
                        if_ack_o  <= 1'b1;
                        if_data_o <= timed_out ? 32'd0 : bus_rdata_i;
                    end
                end
            end else if (state != IDLE) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign stallreq_o = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);

endmodule
